// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: default data width,
// register-number width, FSM state encoding and a small width helper.
package cdb_arbiter_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_W    = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,   // bus empty
    ST_BUSY = 1'b1    // bus holds a broadcast
  } state_e;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Wrapping priority search: returns the first set req bit at or after ptr,
// wrapping modulo PORTS, as both a one-hot pick and a binary index.
module rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int IDX_W = idx_width(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [PORTS-1:0] pick,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  logic w_found;

  // Scan PORTS positions starting at ptr; the first requester seen wins.
  always_comb begin
    int j;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    pick    = '0;
    index   = '0;
    w_found = 1'b0;
    j       = 0;
    for (int i = 0; i < PORTS; i++) begin
      j = (int'(ptr) + i) % PORTS;
      if (!w_found && req[j]) begin
        pick[j] = 1'b1;
        index   = IDX_W'(j);
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among PORTS requesters, one
// registered broadcast slot handed to the ROB with a ready handshake.
// A grant is issued whenever the slot is empty or being drained this cycle,
// so a continuously requesting port sees full throughput.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int PORTS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   bus_ready,
  input  logic [PORTS-1:0]       req,
  input  logic [PORTS*XLEN-1:0]  req_result,
  input  logic [PORTS*XLEN-1:0]  req_address,
  input  logic [PORTS*XLEN-1:0]  req_jmp_address,
  input  logic [PORTS*REG_W-1:0] req_arn,
  input  logic [PORTS*REG_W-1:0] req_rrn,
  input  logic [PORTS-1:0]       req_reg_write,
  output logic [PORTS-1:0]       grant,
  output logic [XLEN-1:0]        result,
  output logic [XLEN-1:0]        address,
  output logic [XLEN-1:0]        jmp_address,
  output logic [REG_W-1:0]       arn,
  output logic [REG_W-1:0]       rrn,
  output logic [PORTS-1:0]       select,
  output logic                   reg_write,
  output logic                   valid
);

  localparam int IDX_W = idx_width(PORTS);

  state_e             r_state;
  state_e             w_state_next;
  logic [IDX_W-1:0]   r_ptr;

  logic [PORTS-1:0]   w_pick;
  logic [IDX_W-1:0]   w_index;
  logic               w_any_req;
  logic               w_can_grant;
  logic               w_grant_any;

  logic [XLEN-1:0]    w_sel_result;
  logic [XLEN-1:0]    w_sel_address;
  logic [XLEN-1:0]    w_sel_jmp_address;
  logic [REG_W-1:0]   w_sel_arn;
  logic [REG_W-1:0]   w_sel_rrn;
  logic               w_sel_reg_write;

  logic [XLEN-1:0]    r_result;
  logic [XLEN-1:0]    r_address;
  logic [XLEN-1:0]    r_jmp_address;
  logic [REG_W-1:0]   r_arn;
  logic [REG_W-1:0]   r_rrn;
  logic [PORTS-1:0]   r_select;
  logic               r_reg_write;
  logic               r_valid;

  rr_picker #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (r_ptr),
    .pick  (w_pick),
    .index (w_index),
    .any   (w_any_req)
  );

  // The slot can take a new broadcast when empty or when the current one is
  // accepted this cycle; reset and flush suppress every grant.
  assign w_can_grant = !reset && !flush && ((r_state == ST_IDLE) || bus_ready);
  assign grant       = w_can_grant ? w_pick : '0;
  assign w_grant_any = |grant;

  // Select the winning requester's payload fields.
  always_comb begin
    w_sel_result      = '0;
    w_sel_address     = '0;
    w_sel_jmp_address = '0;
    w_sel_arn         = '0;
    w_sel_rrn         = '0;
    w_sel_reg_write   = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (w_pick[p]) begin
        w_sel_result      = req_result[p*XLEN +: XLEN];
        w_sel_address     = req_address[p*XLEN +: XLEN];
        w_sel_jmp_address = req_jmp_address[p*XLEN +: XLEN];
        w_sel_arn         = req_arn[p*REG_W +: REG_W];
        w_sel_rrn         = req_rrn[p*REG_W +: REG_W];
        w_sel_reg_write   = req_reg_write[p];
      end
    end
  end

  // Next-state logic: flush empties the bus, otherwise fill on request and
  // drain or refill on each accepted broadcast.
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any_req) w_state_next = ST_BUSY;
        ST_BUSY: if (bus_ready) w_state_next = w_any_req ? ST_BUSY : ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Round-robin pointer: moves just past each winner, kept across flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant_any) begin
      r_ptr <= (w_index == IDX_W'(PORTS - 1)) ? '0 : w_index + 1'b1;
    end
  end

  // Bus slot: load on grant, clear flags once drained, hold while stalled.
  always_ff @(posedge clk) begin
    // NOTE: only control and payload flops here, so a full reset is cheap and
    // keeps every output defined from the first cycle.
    if (reset || flush) begin
      r_result      <= '0;
      r_address     <= '0;
      r_jmp_address <= '0;
      r_arn         <= '0;
      r_rrn         <= '0;
      r_select      <= '0;
      r_reg_write   <= 1'b0;
      r_valid       <= 1'b0;
    end else if (w_grant_any) begin
      r_result      <= w_sel_result;
      r_address     <= w_sel_address;
      r_jmp_address <= w_sel_jmp_address;
      r_arn         <= w_sel_arn;
      r_rrn         <= w_sel_rrn;
      r_select      <= grant;
      r_reg_write   <= w_sel_reg_write;
      r_valid       <= 1'b1;
    end else if (bus_ready) begin
      r_select      <= '0;
      r_reg_write   <= 1'b0;
      r_valid       <= 1'b0;
    end
  end

  assign result      = r_result;
  assign address     = r_address;
  assign jmp_address = r_jmp_address;
  assign arn         = r_arn;
  assign rrn         = r_rrn;
  assign select      = r_select;
  assign reg_write   = r_reg_write;
  assign valid       = r_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: the stimulus process checks grant and
// queues each expected broadcast; a monitor pops and compares whenever the
// bus transfers (valid && bus_ready).
module tb_cdb_arbiter;

  localparam int XLEN  = 32;
  localparam int PORTS = 4;
  localparam int RW    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset = 1'b1;
  logic                  flush = 1'b0;
  logic                  bus_ready = 1'b0;
  logic [PORTS-1:0]      req = '0;
  logic [PORTS*XLEN-1:0] req_result, req_address, req_jmp_address;
  logic [PORTS*RW-1:0]   req_arn, req_rrn;
  logic [PORTS-1:0]      req_reg_write;
  logic [PORTS-1:0]      grant;
  logic [XLEN-1:0]       result, address, jmp_address;
  logic [RW-1:0]         arn, rrn;
  logic [PORTS-1:0]      select;
  logic                  reg_write, valid;

  cdb_arbiter #(.XLEN(XLEN), .PORTS(PORTS)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .bus_ready       (bus_ready),
    .req             (req),
    .req_result      (req_result),
    .req_address     (req_address),
    .req_jmp_address (req_jmp_address),
    .req_arn         (req_arn),
    .req_rrn         (req_rrn),
    .req_reg_write   (req_reg_write),
    .grant           (grant),
    .result          (result),
    .address         (address),
    .jmp_address     (jmp_address),
    .arn             (arn),
    .rrn             (rrn),
    .select          (select),
    .reg_write       (reg_write),
    .valid           (valid)
  );

  logic [XLEN-1:0] b_res [PORTS];
  logic [XLEN-1:0] b_addr[PORTS];
  logic [XLEN-1:0] b_jmp [PORTS];
  logic [RW-1:0]   b_arn [PORTS];
  logic [RW-1:0]   b_rrn [PORTS];
  logic [PORTS-1:0] b_rw;

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      req_result[p*XLEN +: XLEN]      = b_res[p];
      req_address[p*XLEN +: XLEN]     = b_addr[p];
      req_jmp_address[p*XLEN +: XLEN] = b_jmp[p];
      req_arn[p*RW +: RW]             = b_arn[p];
      req_rrn[p*RW +: RW]             = b_rrn[p];
    end
    req_reg_write = b_rw;
  end

  int n_pass  = 0;
  int n_total = 0;
  int tag     = 0;
  bit ov_en   = 1'b0;   // port 2 carries DEADBEEF / rrn 17
  bit chk_zero = 1'b0;  // expect an all-zero bus this step

  logic [127:0] sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Fresh, distinct payload on every port each step.
  task automatic load_payload();
    for (int p = 0; p < PORTS; p++) begin
      b_res[p]  = 32'(tag * 256 + p);
      b_addr[p] = b_res[p] ^ 32'h5555_0000;
      b_jmp[p]  = b_res[p] + 32'h100;
      b_arn[p]  = 6'((tag + p) % 64);
      b_rrn[p]  = 6'((tag * 3 + p) % 64);
      b_rw[p]   = 1'((tag + p) % 2);
    end
    if (ov_en) begin
      b_res[2] = 32'hDEADBEEF;
      b_rrn[2] = 6'd17;
    end
  endtask

  function automatic logic [127:0] exp_of(input int k);
    logic [PORTS-1:0] sel;
    sel = '0;
    sel[k] = 1'b1;
    return 128'({b_res[k], b_addr[k], b_jmp[k], b_arn[k], b_rrn[k], sel, b_rw[k]});
  endfunction

  // One cycle: drive at posedge+1, check grant/valid at negedge.
  task automatic step(input logic [3:0] r, input logic br, input logic fl,
                      input logic [3:0] eg, input logic ev);
    req = r; bus_ready = br; flush = fl;
    tag++;
    load_payload();
    @(negedge clk);
    check("grant", 128'(grant), 128'(eg));
    check("valid", 128'(valid), 128'(ev));
    if (!ev) check("idle_flags", 128'({select, reg_write}), 128'(0));
    if (chk_zero)
      check("flushed_bus", 128'({result, address, jmp_address, arn, rrn, select, reg_write, valid}), 128'(0));
    for (int k = 0; k < PORTS; k++)
      if (eg[k]) sb.push_back(exp_of(k));
    @(posedge clk); #1;
  endtask

  // Monitor: invariants every cycle, payload compare on each transfer.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("grant_onehot0", 128'($onehot0(grant)), 128'(1));
        check("rw_qualified", 128'(reg_write & ~valid), 128'(0));
        if (valid && bus_ready) begin
          check("sb_nonempty", 128'(sb.size() > 0), 128'(1));
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("broadcast", 128'({result, address, jmp_address, arn, rrn, select, reg_write}), e);
          end
        end
      end
    end
  end

  initial begin
    // Reset with every port requesting.
    reset = 1'b1; req = 4'b1111; bus_ready = 1'b1;
    load_payload();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 128'(grant), 128'(0));
    check("rst_outputs", 128'({result, address, jmp_address, arn, rrn, select, reg_write, valid}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // First grant after reset, then full rotation with everyone requesting.
    step(4'b1111, 1, 0, 4'b0001, 0);
    step(4'b1111, 1, 0, 4'b0010, 1);
    step(4'b1111, 1, 0, 4'b0100, 1);
    step(4'b1111, 1, 0, 4'b1000, 1);
    step(4'b1111, 1, 0, 4'b0001, 1);
    step(4'b1111, 1, 0, 4'b0010, 1);
    step(4'b1111, 1, 0, 4'b0100, 1);
    step(4'b1111, 1, 0, 4'b1000, 1);
    step(4'b1111, 1, 0, 4'b0001, 1);
    step(4'b0000, 1, 0, 4'b0000, 1);
    step(4'b0000, 1, 0, 4'b0000, 0);

    // Single requester 2 with a recognisable payload.
    ov_en = 1'b1;
    step(4'b0100, 1, 0, 4'b0100, 0);
    ov_en = 1'b0;
    step(4'b0000, 1, 0, 4'b0000, 1);

    // Stall for three cycles; payload must survive unchanged.
    step(4'b0011, 1, 0, 4'b0001, 0);
    step(4'b0011, 0, 0, 4'b0000, 1);
    step(4'b0011, 0, 0, 4'b0000, 1);
    step(4'b0011, 0, 0, 4'b0000, 1);
    step(4'b0011, 1, 0, 4'b0010, 1);
    step(4'b0011, 1, 0, 4'b0001, 1);
    step(4'b0000, 1, 0, 4'b0000, 1);

    // Flush while busy: the pending broadcast is discarded.
    step(4'b1000, 1, 0, 4'b1000, 0);
    void'(sb.pop_back());
    step(4'b1000, 0, 1, 4'b0000, 1);
    chk_zero = 1'b1;
    step(4'b1000, 1, 0, 4'b1000, 0);
    chk_zero = 1'b0;
    step(4'b0000, 1, 0, 4'b0000, 1);

    // Reset (with flush also high) in the middle of a broadcast.
    step(4'b0010, 0, 0, 4'b0010, 0);
    reset = 1'b1; flush = 1'b1; req = 4'b0010; bus_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_grant", 128'(grant), 128'(0));
    @(negedge clk);
    check("midrst_grant2", 128'(grant), 128'(0));
    check("midrst_outputs", 128'({result, address, jmp_address, arn, rrn, select, reg_write, valid}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0;

    // Pointer restarts at 0; then one requester at full throughput.
    step(4'b0110, 1, 0, 4'b0010, 0);
    step(4'b0110, 1, 0, 4'b0100, 1);
    step(4'b0001, 1, 0, 4'b0001, 1);
    step(4'b0001, 1, 0, 4'b0001, 1);
    step(4'b0001, 1, 0, 4'b0001, 1);
    step(4'b0000, 1, 0, 4'b0000, 1);
    step(4'b0000, 1, 0, 4'b0000, 0);

    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
